mmnet_layer_sequencer: RTL and testbench

- Sequences a single shared compute engine through the four network stages: conv, dwcv, fc1, fc2.
- Issues one engine job per output channel or neuron, in order. Each job is tagged with its layer, its channel index, its weight base address and the ping-pong activation buffer selects.
- Sits between the host-side start/done interface and the engine. The engine's internals are outside this block.

---
 rtl/mmnet_pkg.sv | 62 ++++++
 rtl/mmnet_layer_sequencer_if.sv | 33 +++
 rtl/mmnet_layer_sequencer.sv | 126 ++++++++++++
 tb/tb_mmnet_layer_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmnet_pkg.sv
// Shared types, sizing constants and per-layer lookups for the mmnet layer sequencer.
package mmnet_pkg;

    // Jobs (output channels / neurons) issued per stage
    localparam int CONV_CH = 6;
    localparam int DWCV_CH = 16;
    localparam int FC1_CH  = 84;
    localparam int FC2_CH  = 10;

    // Weight words consumed by one job of each stage
    localparam int CONV_KW = 27;
    localparam int DWCV_KW = 54;
    localparam int FC1_KW  = 576;
    localparam int FC2_KW  = 84;

    localparam int ADDR_W = 16;
    localparam int CH_W   = 7;

    // Weight regions are packed back to back in stage order
    localparam int CONV_BASE   = 0;
    localparam int DWCV_BASE   = CONV_BASE + CONV_CH * CONV_KW;
    localparam int FC1_BASE    = DWCV_BASE + DWCV_CH * DWCV_KW;
    localparam int FC2_BASE    = FC1_BASE + FC1_CH * FC1_KW;
    localparam int TOTAL_WORDS = FC2_BASE + FC2_CH * FC2_KW;

    typedef enum logic [1:0] {
        LAYER_CONV = 2'd0,
        LAYER_DWCV = 2'd1,
        LAYER_FC1  = 2'd2,
        LAYER_FC2  = 2'd3
    } layer_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_FINISH  = 3'd4,
        ST_DRAIN   = 3'd5
    } seq_state_t;

    // Index of the final job in a stage
    function automatic logic [CH_W-1:0] last_channel(input layer_t layer);
        case (layer)
            LAYER_CONV: return CH_W'(CONV_CH - 1);
            LAYER_DWCV: return CH_W'(DWCV_CH - 1);
            LAYER_FC1:  return CH_W'(FC1_CH - 1);
            default:    return CH_W'(FC2_CH - 1);
        endcase
    endfunction

    // Weight-address stride between consecutive jobs of a stage
    function automatic logic [ADDR_W-1:0] layer_kw(input layer_t layer);
        case (layer)
            LAYER_CONV: return ADDR_W'(CONV_KW);
            LAYER_DWCV: return ADDR_W'(DWCV_KW);
            LAYER_FC1:  return ADDR_W'(FC1_KW);
            default:    return ADDR_W'(FC2_KW);
        endcase
    endfunction

endpackage

// File: rtl/mmnet_layer_sequencer_if.sv
// Host start/done handshake plus engine job bus of the layer sequencer.
interface mmnet_layer_sequencer_if;
    import mmnet_pkg::*;

    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              eng_start;
    logic              eng_done;
    logic [1:0]        eng_layer;
    logic [CH_W-1:0]   eng_channel;
    logic [ADDR_W-1:0] eng_wbase;
    logic              eng_src_buf;
    logic              eng_dst_buf;
    logic              err_spurious;

    // Sequencer side
    modport master (
        input  start, abort, eng_done,
        output busy, done, aborted, eng_start, eng_layer, eng_channel,
               eng_wbase, eng_src_buf, eng_dst_buf, err_spurious
    );

    // Host / engine side
    modport slave (
        output start, abort, eng_done,
        input  busy, done, aborted, eng_start, eng_layer, eng_channel,
               eng_wbase, eng_src_buf, eng_dst_buf, err_spurious
    );

endinterface

// File: rtl/mmnet_layer_sequencer.sv
// Walks the shared compute engine through conv, dwcv, fc1 and fc2, one job per
// output channel, handing each job its layer, channel, weight base and buffers.
module mmnet_layer_sequencer
    import mmnet_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mmnet_layer_sequencer_if.master bus
);

    seq_state_t        state,   state_next;
    layer_t            layer,   layer_next;
    logic [CH_W-1:0]   channel, channel_next;
    logic [ADDR_W-1:0] wbase,   wbase_next;
    logic              aborted_q, aborted_next;
    logic              err_q,     err_next;

    // State and job-descriptor registers; rst returns everything to idle zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            layer     <= LAYER_CONV;
            channel   <= '0;
            wbase     <= '0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            layer     <= layer_next;
            channel   <= channel_next;
            wbase     <= wbase_next;
            aborted_q <= aborted_next;
            err_q     <= err_next;
        end
    end

    // Next-state logic: job stepping, layer rollover and the abort/drain paths
    always_comb begin
        state_next   = state;
        layer_next   = layer;
        channel_next = channel;
        wbase_next   = wbase;
        aborted_next = 1'b0;
        // eng_done is only legitimate while a job is outstanding
        err_next     = err_q | (bus.eng_done & (state != ST_WAIT) & (state != ST_DRAIN));

        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_next   = ST_ISSUE;
                    layer_next   = LAYER_CONV;
                    channel_next = '0;
                    wbase_next   = '0;
                end
            end
            ST_ISSUE: begin
                if (bus.abort) begin
                    state_next   = ST_IDLE;
                    aborted_next = 1'b1;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.abort) begin
                    // a job in flight must finish before we let go of the engine
                    if (bus.eng_done) begin
                        state_next   = ST_IDLE;
                        aborted_next = 1'b1;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end else if (bus.eng_done) begin
                    state_next = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (bus.abort) begin
                    state_next   = ST_IDLE;
                    aborted_next = 1'b1;
                end else begin
                    wbase_next = wbase + layer_kw(layer);
                    if (channel == last_channel(layer)) begin
                        if (layer == LAYER_FC2) begin
                            state_next = ST_FINISH;
                        end else begin
                            layer_next   = layer_t'(layer + 2'd1);
                            channel_next = '0;
                            state_next   = ST_ISSUE;
                        end
                    end else begin
                        channel_next = channel + CH_W'(1);
                        state_next   = ST_ISSUE;
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.eng_done) begin
                    state_next   = ST_IDLE;
                    aborted_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A launch cancelled by abort in the same cycle is never shown to the engine
    assign bus.eng_start    = (state == ST_ISSUE) && !bus.abort;
    assign bus.busy         = (state == ST_ISSUE) || (state == ST_WAIT) ||
                              (state == ST_ADVANCE) || (state == ST_DRAIN);
    assign bus.done         = (state == ST_FINISH);
    assign bus.aborted      = aborted_q;
    assign bus.err_spurious = err_q;
    assign bus.eng_layer    = layer;
    assign bus.eng_channel  = channel;
    assign bus.eng_wbase    = wbase;
    // Ping-pong: even layers read buffer 0 and write 1, odd layers the reverse
    assign bus.eng_src_buf  = layer[0];
    assign bus.eng_dst_buf  = (state != ST_IDLE) & ~layer[0];

endmodule

// File: tb/tb_mmnet_layer_sequencer.sv
// Directed self-checking bench for mmnet_layer_sequencer with a simple engine model.
module tb_mmnet_layer_sequencer;
    import mmnet_pkg::*;

    localparam int TOTAL_JOBS = 116;
    localparam int MAX_REC    = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mmnet_layer_sequencer_if bus();

    mmnet_layer_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int cyc           = 0;
    int njobs         = 0;
    int done_cnt      = 0;
    int aborted_cnt   = 0;
    int last_done_cyc = -100;
    int run_base      = 0;
    bit hold_dwcv7    = 1'b0;

    logic [1:0]        job_layer [MAX_REC];
    logic [CH_W-1:0]   job_ch    [MAX_REC];
    logic [ADDR_W-1:0] job_wb    [MAX_REC];
    logic              job_src   [MAX_REC];
    logic              job_dst   [MAX_REC];
    int                job_gap   [MAX_REC];

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to time gaps between engine handshakes
    always @(posedge clk) cyc <= cyc + 1;

    // Record every launched job and count done/aborted pulses mid-cycle
    always @(negedge clk) begin
        if (bus.eng_start === 1'b1) begin
            if (njobs < MAX_REC) begin
                job_layer[njobs] = bus.eng_layer;
                job_ch[njobs]    = bus.eng_channel;
                job_wb[njobs]    = bus.eng_wbase;
                job_src[njobs]   = bus.eng_src_buf;
                job_dst[njobs]   = bus.eng_dst_buf;
                job_gap[njobs]   = cyc - last_done_cyc;
            end
            njobs++;
        end
        if (bus.eng_done === 1'b1) last_done_cyc = cyc;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.aborted === 1'b1) aborted_cnt++;
    end

    // Engine model: acks 3 cycles after launch, 13 for the held dwcv channel 7 job
    initial begin
        int d;
        bus.eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.eng_start === 1'b1) begin
                d = (hold_dwcv7 && bus.eng_layer == 2'd1 && bus.eng_channel == 7'd7) ? 13 : 3;
                repeat (d) @(posedge clk);
                #1 bus.eng_done = 1'b1;
                @(posedge clk);
                #1 bus.eng_done = 1'b0;
            end
        end
    end

    function automatic logic [31:0] outs();
        return {bus.busy, bus.done, bus.aborted, bus.eng_start, bus.eng_layer,
                bus.eng_channel, bus.eng_wbase, bus.eng_src_buf, bus.eng_dst_buf,
                bus.err_spurious};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            sample();
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_job(input logic [1:0] l, input logic [CH_W-1:0] c, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            sample();
            if (bus.eng_start === 1'b1 && bus.eng_layer == l && bus.eng_channel == c) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        sample();
        tests_run++;
        if (outs() !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", outs(), 32'h0);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_full_run();
        int cnt [4] = '{6, 16, 84, 10};
        int kw  [4] = '{27, 54, 576, 84};
        int d0, idx, wb;
        bit ok;
        logic [26:0] expv, got;
        run_base = njobs;
        d0 = done_cnt;
        tick();
        bus.start = 1'b1;
        sample();
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL busy_at_start: got %b expected 0", bus.busy);
        end
        tick();
        bus.start = 1'b0;
        sample();
        tests_run++;
        if ({bus.busy, bus.eng_start} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL first_issue: busy,eng_start got %b expected 11", {bus.busy, bus.eng_start});
        end
        wait_idle(2000, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL full_run_timeout: busy still %b expected 0", bus.busy);
        end
        tests_run++;
        if (bus.done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL done_with_busy_low: got done %b expected 1", bus.done);
        end
        sample();
        tests_run++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL after_done: done,busy got %b expected 00", {bus.done, bus.busy});
        end
        tests_run++;
        if (njobs - run_base != TOTAL_JOBS) begin
            tests_failed++;
            $display("[TB] FAIL job_count: got %0d expected %0d", njobs - run_base, TOTAL_JOBS);
        end
        tests_run++;
        if (done_cnt - d0 != 1) begin
            tests_failed++;
            $display("[TB] FAIL done_pulses: got %0d expected 1", done_cnt - d0);
        end
        idx = run_base;
        wb = 0;
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < cnt[l]; c++) begin
                expv = {2'(l), 7'(c), 16'(wb), 1'(l & 1), 1'((l & 1) ^ 1)};
                got  = {job_layer[idx], job_ch[idx], job_wb[idx], job_src[idx], job_dst[idx]};
                tests_run++;
                if (got !== expv) begin
                    tests_failed++;
                    $display("[TB] FAIL job_%0d: got %h expected %h", idx - run_base, got, expv);
                end
                wb += kw[l];
                idx++;
            end
        end
        tests_run++;
        if (job_wb[run_base + 22] !== 16'd1026) begin
            tests_failed++;
            $display("[TB] FAIL fc1_first_wbase: got %0d expected 1026", job_wb[run_base + 22]);
        end
        tests_run++;
        if ({job_layer[run_base + 115], job_ch[run_base + 115], job_wb[run_base + 115]} !== {2'd3, 7'd9, 16'd50166}) begin
            tests_failed++;
            $display("[TB] FAIL fc2_last_job: got layer %0d ch %0d wbase %0d expected 3 9 50166",
                     job_layer[run_base + 115], job_ch[run_base + 115], job_wb[run_base + 115]);
        end
    endtask

    task automatic test_layer_boundary();
        tests_run++;
        if ({job_layer[run_base + 5], job_ch[run_base + 5], job_wb[run_base + 5]} !== {2'd0, 7'd5, 16'd135}) begin
            tests_failed++;
            $display("[TB] FAIL last_conv_job: got layer %0d ch %0d wbase %0d expected 0 5 135",
                     job_layer[run_base + 5], job_ch[run_base + 5], job_wb[run_base + 5]);
        end
        tests_run++;
        if ({job_layer[run_base + 6], job_ch[run_base + 6], job_wb[run_base + 6], job_src[run_base + 6], job_dst[run_base + 6]}
            !== {2'd1, 7'd0, 16'd162, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL first_dwcv_job: got layer %0d ch %0d wbase %0d src %b dst %b expected 1 0 162 1 0",
                     job_layer[run_base + 6], job_ch[run_base + 6], job_wb[run_base + 6],
                     job_src[run_base + 6], job_dst[run_base + 6]);
        end
        tests_run++;
        if (job_gap[run_base + 6] != 2) begin
            tests_failed++;
            $display("[TB] FAIL boundary_gap: got %0d cycles expected 2", job_gap[run_base + 6]);
        end
    endtask

    task automatic test_spurious();
        int n0, d0;
        bit ok;
        sample();
        tests_run++;
        if (bus.err_spurious !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_before_spurious: got %b expected 0", bus.err_spurious);
        end
        n0 = njobs;
        tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        sample();
        tests_run++;
        if ({bus.err_spurious, bus.busy} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL spurious_idle: err,busy got %b expected 10", {bus.err_spurious, bus.busy});
        end
        d0 = done_cnt;
        pulse_start();
        wait_idle(2000, ok);
        sample();
        tests_run++;
        if (njobs - n0 != TOTAL_JOBS || done_cnt - d0 != 1 || !ok) begin
            tests_failed++;
            $display("[TB] FAIL run_after_spurious: got jobs %0d dones %0d expected 116 1", njobs - n0, done_cnt - d0);
        end
        tests_run++;
        if (bus.err_spurious !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_sticky: got %b expected 1", bus.err_spurious);
        end
    endtask

    task automatic test_abort();
        int n0, d0, a0, n_abort, early, drop;
        bit ok;
        n0 = njobs;
        d0 = done_cnt;
        hold_dwcv7 = 1'b1;
        pulse_start();
        wait_job(2'd1, 7'd7, 1000, ok);
        hold_dwcv7 = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL abort_reach_dwcv7: got timeout expected job dwcv 7");
        end
        tick();
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_abort = njobs;
        a0 = aborted_cnt;
        early = 0;
        drop = 0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (bus.aborted !== 1'b0) early++;
            if (bus.busy !== 1'b1) drop++;
        end
        tests_run++;
        if (early != 0 || drop != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain_hold: early aborted %0d busy drops %0d expected 0 0", early, drop);
        end
        sample();
        tests_run++;
        if ({bus.aborted, bus.busy, bus.done} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL aborted_pulse: aborted,busy,done got %b expected 100", {bus.aborted, bus.busy, bus.done});
        end
        sample();
        tests_run++;
        if (bus.aborted !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL aborted_width: got %b expected 0", bus.aborted);
        end
        tests_run++;
        if (njobs != n_abort || njobs - n0 != 14 || done_cnt != d0 || aborted_cnt != a0 + 1) begin
            tests_failed++;
            $display("[TB] FAIL abort_counts: got jobs %0d dones %0d aborts %0d expected 14 0 1",
                     njobs - n0, done_cnt - d0, aborted_cnt - a0);
        end
    endtask

    task automatic test_start_abort_idle();
        int n0, a0, seen;
        n0 = njobs;
        a0 = aborted_cnt;
        seen = 0;
        tick();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            if (bus.busy !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0 || njobs != n0 || aborted_cnt != a0) begin
            tests_failed++;
            $display("[TB] FAIL start_abort_idle: busy cycles %0d jobs %0d aborts %0d expected 0 0 0",
                     seen, njobs - n0, aborted_cnt - a0);
        end
    endtask

    task automatic test_start_while_busy();
        int n0, d0, late;
        bit ok;
        n0 = njobs;
        d0 = done_cnt;
        pulse_start();
        repeat (20) sample();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle(2000, ok);
        late = 0;
        for (int k = 0; k < 5; k++) begin
            sample();
            if (bus.busy !== 1'b0) late++;
        end
        tests_run++;
        if (!ok || njobs - n0 != TOTAL_JOBS || done_cnt - d0 != 1 || late != 0) begin
            tests_failed++;
            $display("[TB] FAIL start_while_busy: jobs %0d dones %0d busy after %0d expected 116 1 0",
                     njobs - n0, done_cnt - d0, late);
        end
    endtask

    task automatic test_rst_mid();
        int n0, d0, a0;
        bit ok;
        pulse_start();
        wait_job(2'd2, 7'd0, 1000, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL rst_reach_fc1: got timeout expected job fc1 0");
        end
        d0 = done_cnt;
        a0 = aborted_cnt;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        tests_run++;
        if (outs() !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_outputs: got %h expected %h", outs(), 32'h0);
        end
        repeat (6) sample();
        tests_run++;
        if (done_cnt != d0 || aborted_cnt != a0) begin
            tests_failed++;
            $display("[TB] FAIL rst_no_pulses: dones %0d aborts %0d expected 0 0", done_cnt - d0, aborted_cnt - a0);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n0 = njobs;
        pulse_start();
        sample();
        tests_run++;
        if ({bus.eng_start, bus.eng_layer, bus.eng_channel, bus.eng_wbase} !== {1'b1, 2'd0, 7'd0, 16'd0}) begin
            tests_failed++;
            $display("[TB] FAIL restart_first_job: got start %b layer %0d ch %0d wbase %0d expected 1 0 0 0",
                     bus.eng_start, bus.eng_layer, bus.eng_channel, bus.eng_wbase);
        end
        wait_idle(2000, ok);
        tests_run++;
        if (!ok || njobs - n0 != TOTAL_JOBS) begin
            tests_failed++;
            $display("[TB] FAIL restart_run: jobs %0d expected 116", njobs - n0);
        end
    endtask

    // Scenario sequence and summary
    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_full_run();
        test_layer_boundary();
        test_spurious();
        test_abort();
        test_start_abort_idle();
        test_start_while_busy();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
